// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide steps on
// operand magnitudes, then sign correction, with a one-cycle register-file write strobe.
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int ITERATIONS = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [4:0]      dest_register,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      result_register,
    output logic            register_write
);

    localparam int CW = $clog2(ITERATIONS);
    localparam logic [CW-1:0] LAST_STEP = CW'(ITERATIONS - 1);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t            state, state_next;
    logic [2:0]        op;
    logic              a_neg, b_neg, b_zero;
    logic [XLEN-1:0]   mag_op;        // multiplicand for MUL*, divisor for DIV*/REM*
    logic [2*XLEN-1:0] acc;           // {product} or {remainder, quotient}
    logic [CW-1:0]     counter;
    logic [4:0]        rd;

    // Operand preparation, evaluated on the live inputs for the accepting edge.
    logic            a_signed_in, b_signed_in, a_neg_in, b_neg_in;
    logic [XLEN-1:0] mag_a_in, mag_b_in;

    assign a_signed_in = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign b_signed_in = funct3[2] ? ~funct3[0] : ~funct3[1];
    assign a_neg_in    = a_signed_in & operand_a[XLEN-1];
    assign b_neg_in    = b_signed_in & operand_b[XLEN-1];
    assign mag_a_in    = a_neg_in ? -operand_a : operand_a;
    assign mag_b_in    = b_neg_in ? -operand_b : operand_b;

    // One iteration of each algorithm.
    logic [XLEN:0]     mul_sum, rem_shift;
    logic [XLEN-1:0]   rem_sub;
    logic              rem_ge;
    logic [2*XLEN-1:0] mul_step, div_step;

    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_op} : '0);
    assign mul_step  = {mul_sum, acc[XLEN-1:1]};
    assign rem_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign rem_ge    = rem_shift >= {1'b0, mag_op};
    assign rem_sub   = rem_shift[XLEN-1:0] - mag_op;
    assign div_step  = {(rem_ge ? rem_sub : rem_shift[XLEN-1:0]), acc[XLEN-2:0], rem_ge};

    // Sign correction and special cases.
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   quotient, remainder, final_value;

    assign product   = (a_neg ^ b_neg) ? -acc : acc;
    assign quotient  = acc[XLEN-1:0];
    assign remainder = acc[2*XLEN-1:XLEN];

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        final_value = product[XLEN-1:0];
        if (!op[2]) begin
            final_value = (op[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
        end else if (!op[1]) begin
            final_value = b_zero ? '1 : ((a_neg ^ b_neg) ? -quotient : quotient);
        end else begin
            // Divide-by-zero leaves the dividend magnitude as remainder, so REM returns operand_a.
            final_value = a_neg ? -remainder : remainder;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && !flush && !done) state_next = CALC;
            CALC:    if (flush) state_next = IDLE;
                     else if (counter == LAST_STEP) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op              <= '0;
            a_neg           <= 1'b0;
            b_neg           <= 1'b0;
            b_zero          <= 1'b0;
            mag_op          <= '0;
            acc             <= '0;
            counter         <= '0;
            rd              <= '0;
            done            <= 1'b0;
            register_write  <= 1'b0;
            result          <= '0;
            result_register <= '0;
        end else begin
            done           <= 1'b0;
            register_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (state_next == CALC) begin
                        op      <= funct3;
                        a_neg   <= a_neg_in;
                        b_neg   <= b_neg_in;
                        b_zero  <= (operand_b == '0);
                        mag_op  <= funct3[2] ? mag_b_in : mag_a_in;
                        acc     <= {{XLEN{1'b0}}, (funct3[2] ? mag_a_in : mag_b_in)};
                        counter <= '0;
                        rd      <= dest_register;
                    end
                end
                CALC: begin
                    if (!flush) begin
                        acc     <= op[2] ? div_step : mul_step;
                        counter <= counter + 1'b1;
                    end
                end
                FINISH: begin
                    if (!flush) begin
                        result          <= final_value;
                        result_register <= rd;
                        done            <= 1'b1;
                        register_write  <= (rd != 5'd0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: per-cycle comparison of busy/done/write-back
// against a latency-window model with plain RV32M arithmetic, plus directed literal checks.
module tb_muldiv_unit;

    logic        clock, reset, start, flush;
    logic [2:0]  funct3;
    logic [31:0] operand_a, operand_b;
    logic [4:0]  dest_register;
    logic        busy, done, register_write;
    logic [31:0] result;
    logic [4:0]  result_register;

    muldiv_unit dut (
        .clock(clock), .reset(reset), .start(start), .flush(flush),
        .funct3(funct3), .operand_a(operand_a), .operand_b(operand_b),
        .dest_register(dest_register), .busy(busy), .done(done),
        .result(result), .result_register(result_register),
        .register_write(register_write)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference model state: one accepted operation at most.
    logic        pending = 1'b0;
    int          start_edge = 0;
    int          last_done = -1;
    logic [2:0]  p_f3;
    logic [31:0] p_a, p_b;
    logic [4:0]  p_rd;
    logic [31:0] held_result = '0;
    logic [4:0]  held_rd = '0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, actual, expected);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        int          ia, ib;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ub = longint'({32'b0, b});
        ia = a;
        ib = b;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Compare process: busy for 33 cycles after the accepting edge, done in the 34th.
    always @(negedge clock) begin
        logic exp_busy, exp_done;
        exp_busy = pending && cyc >= start_edge && cyc <= start_edge + 32;
        exp_done = pending && cyc == start_edge + 33;
        if (exp_done) begin
            held_result = model(p_f3, p_a, p_b);
            held_rd     = p_rd;
            pending     = 1'b0;
            last_done   = cyc;
        end
        check("busy", 32'(busy), 32'(exp_busy));
        check("done", 32'(done), 32'(exp_done));
        check("register_write", 32'(register_write), 32'(exp_done && held_rd != 0));
        check("result", result, held_result);
        check("result_register", 32'(result_register), 32'(held_rd));
    end

    // Drive one cycle of inputs and tell the model what the next edge does with them.
    task automatic drive_cycle(input logic s, input logic f, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        @(negedge clock);
        #1;
        start = s; flush = f; funct3 = f3; operand_a = a; operand_b = b; dest_register = rd;
        if (f) begin
            pending = 1'b0;
        end else if (s && !pending && last_done != cyc && !reset) begin
            pending = 1'b1; start_edge = cyc + 1;
            p_f3 = f3; p_a = a; p_b = b; p_rd = rd;
        end
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, 1'b0, 3'($urandom), $urandom, $urandom, 5'($urandom));
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 80 && pending; n++) idle_cycle();
        if (pending) begin
            miscompares++;
            pending = 1'b0;
            $display("FAIL completion timeout at cycle %0d: got no done, expected done", cyc);
        end
    endtask

    task automatic run(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] expected);
        drive_cycle(1'b1, 1'b0, f3, a, b, rd);
        wait_idle();
        check(name, result, expected);
        check({name, "_rd"}, 32'(result_register), 32'(rd));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0;
        operand_a = '0; operand_b = '0; dest_register = '0;
        repeat (3) @(negedge clock);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_result", result, 32'd0);
        reset = 1'b0;

        run("mul_7x6",      3'd0, 32'd7,          32'd6,          5'd5,  32'h0000_002A);
        run("mulh_m1xm1",   3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'h0000_0000);
        run("mulhu_ffxff",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE);
        run("mulhsu_ffxff", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd3,  32'hFFFF_FFFF);
        run("mul_min_x2",   3'd0, 32'h8000_0000,  32'd2,          5'd4,  32'h0000_0000);
        run("div_m7_2",     3'd4, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFD);
        run("rem_m7_2",     3'd6, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFF);
        run("divu_100_7",   3'd5, 32'd100,        32'd7,          5'd8,  32'd14);
        run("remu_100_7",   3'd7, 32'd100,        32'd7,          5'd9,  32'd2);
        run("divu_by0",     3'd5, 32'd5,          32'd0,          5'd10, 32'hFFFF_FFFF);
        run("rem_by0",      3'd6, 32'd5,          32'd0,          5'd11, 32'd5);
        run("div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h8000_0000);
        run("rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'd0);
        run("mul_rd0",      3'd0, 32'd3,          32'd3,          5'd0,  32'd9);

        // A second start while busy is ignored.
        drive_cycle(1'b1, 1'b0, 3'd0, 32'd7, 32'd6, 5'd5);
        repeat (4) idle_cycle();
        drive_cycle(1'b1, 1'b0, 3'd3, 32'd100, 32'd100, 5'd9);
        wait_idle();
        check("restart_ignored", result, 32'h0000_002A);
        check("restart_ignored_rd", 32'(result_register), 32'd5);

        // Flush at cycle 10 kills the operation; the previous result holds.
        drive_cycle(1'b1, 1'b0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20);
        repeat (9) idle_cycle();
        drive_cycle(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 5'd0);
        repeat (40) idle_cycle();
        check("flush_result_held", result, 32'h0000_002A);

        // Flush and start together in IDLE: nothing accepted.
        drive_cycle(1'b1, 1'b1, 3'd0, 32'd1, 32'd1, 5'd1);
        repeat (40) idle_cycle();

        // Asynchronous reset mid-CALC.
        drive_cycle(1'b1, 1'b0, 3'd0, 32'd11, 32'd11, 5'd3);
        repeat (5) idle_cycle();
        @(negedge clock);
        #1;
        reset = 1'b1;
        pending = 1'b0; held_result = '0; held_rd = '0;
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_result", result, 32'd0);
        check("midreset_rd", 32'(result_register), 32'd0);
        repeat (2) idle_cycle();
        @(negedge clock);
        #1;
        reset = 1'b0;
        run("after_reset_mul", 3'd0, 32'd7, 32'd6, 5'd5, 32'h0000_002A);

        // Randomized operations with occasional flushes and ignored restarts.
        for (int i = 0; i < 150; i++) begin
            int mode;
            mode = $urandom_range(0, 5);
            drive_cycle(1'b1, 1'b0, 3'($urandom), pick_operand(), pick_operand(), 5'($urandom));
            if (mode == 0) begin
                repeat ($urandom_range(0, 34)) idle_cycle();
                drive_cycle(1'b0, 1'b1, 3'($urandom), $urandom, $urandom, 5'($urandom));
            end else if (mode == 1) begin
                repeat ($urandom_range(0, 32)) idle_cycle();
                drive_cycle(1'b1, 1'b0, 3'($urandom), $urandom, $urandom, 5'($urandom));
            end
            wait_idle();
        end

        repeat (2) idle_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execute unit, directly downstream of the register file. It takes the two source operand read values plus the destination register index and computes over multiple cycles. It returns a result with a one-cycle write-back strobe, shaped to drive the register file write port.

Parameters:
XLEN, 32, operand/result width; only 32 supported.
ITERATIONS, 32, shift-add / restoring-divide steps; must equal XLEN.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
flush  input  1  synchronous kill of in-flight operation
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand_a  input  32  rs1 value (multiplicand/dividend)
operand_b  input  32  rs2 value (multiplier/divisor)
dest_register  input  5  rd index for the write-back
busy  output  1  high while in CALC or FINISH
done  output  1  one-cycle completion pulse
result  output  32  computed value; holds until next completion
result_register  output  5  rd index paired with result
register_write  output  1  write strobe, identical to done; forced 0 when result_register==0

Behaviour:
- Clock is `clock`; reset is `reset`, asynchronous and active-high.
- Reset, asynchronous: state=IDLE; busy, done, register_write = 0; result = 0; result_register = 0; internal accumulators/counter = 0.
- States:
  - IDLE: start=1 at a rising edge latches funct3, operands and dest_register, computes operand magnitudes and sign flags, then goes to CALC with counter=0.
  - CALC: one iteration per cycle; counter increments; after the iteration with counter==31, goes to FINISH.
  - FINISH: applies sign correction and special cases, drives result/result_register, pulses done; next state IDLE.
- Latency is fixed for all ops, including special cases: done is high in the cycle after the 33rd rising edge following the start-sampling edge. Exactly one cycle.
- start while busy is ignored with no queueing. start in the same cycle done is high is ignored; the earliest new acceptance is the cycle after done.
- Operands are captured at start; later changes on operand inputs have no effect.
- Multiply:
  - 64-bit shift-add product of magnitudes.
  - MUL returns low 32 bits.
  - MULH/MULHSU/MULHU return the high 32 bits of the signed×signed, signed×unsigned and unsigned×unsigned product respectively.
  - Sign correction is two's-complement negation of the 64-bit product.
- Divide: restoring division on magnitudes.
  - Quotient is negated if operand signs differ (DIV).
  - Remainder takes the dividend's sign (REM).
- Divisor==0:
  - DIV/DIVU → 0xFFFFFFFF.
  - REM/REMU → operand_a.
- Signed overflow (0x80000000 / 0xFFFFFFFF):
  - DIV → 0x80000000.
  - REM → 0.
- Flush:
  - In CALC or FINISH: next edge returns to IDLE, done/register_write stay 0, and result/result_register keep their previous values.
  - Flush in IDLE is a no-op.
  - Flush and start together in IDLE: flush wins and nothing is accepted.
- Reset mid-operation aborts immediately (asynchronous); no done follows.

Test Plan:
- MUL, operand_a=7, operand_b=6, dest_register=5, start one cycle → busy next cycle; done/register_write pulse after 33 edges; result=0x0000002A; result_register=5.
- MULH, 0xFFFFFFFF×0xFFFFFFFF → 0x00000000. MULHU, same operands → 0xFFFFFFFE. MULHSU, same operands → 0xFFFFFFFF. MUL, 0x80000000×2 → 0x00000000.
- DIV, 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM, same operands → 0xFFFFFFFF. DIVU, 100/7 → 14. REMU, 100/7 → 2.
- DIVU, 5/0 → 0xFFFFFFFF. REM, 5/0 → 5. DIV, 0x80000000/0xFFFFFFFF → 0x80000000. REM, same operands → 0. Each completes at the same 33-edge latency.
- start re-asserted with new operands at cycle 5 of a MUL → ignored, original result delivered. dest_register=0 → done=1, register_write=0.
- flush at cycle 10 → busy low after next edge, no done, result unchanged. reset asserted mid-CALC → busy/done/result/result_register=0 immediately. A start after reset release → normal 33-edge completion.
